// File: rtl/mult_div_sequencer_pkg.sv
// md_pkg: op codes, sequencer states and shared ALU opcodes for mult_div_sequencer
package md_pkg;
  typedef enum logic [1:0] {MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11} md_op_e;
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} md_state_e;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
endpackage

// File: rtl/mult_div_sequencer_if.sv
// mult_div_sequencer_if: request (start/op/A/B), shared ALU (alu_*), status (busy/done) and HI/LO bundle
interface mult_div_sequencer_if;
  logic start;
  logic [1:0] op;
  logic [31:0] A, B, alu_result, alu_a, alu_b, hi, lo;
  logic [2:0] alu_control;
  logic alu_req, busy, done;
  modport master (output start, op, A, B, alu_result, input alu_req, alu_a, alu_b, alu_control, busy, done, hi, lo);
  modport slave (input start, op, A, B, alu_result, output alu_req, alu_a, alu_b, alu_control, busy, done, hi, lo);
endinterface

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: 32-iteration shift-add multiply / restoring divide on a shared ALU; clk, reset, bus (slave) with request, ALU, status and HI/LO
module mult_div_sequencer
  import md_pkg::*;
(
  input logic clk,
  input logic reset,
  mult_div_sequencer_if.slave bus
);
  md_state_e st, st_n;
  logic [1:0] op_r;
  logic [31:0] a_r, b_r, a_abs, b_abs, acc, mq, s, hi_r, lo_r;
  logic [63:0] prod;
  logic [4:0] cnt;
  logic neg_res, neg_rem, is_div, sgn, dz, take, carry;
  assign is_div = op_r[1];
  assign sgn = ~op_r[0];
  assign a_abs = sgn && a_r[31] ? -a_r : a_r;
  assign b_abs = sgn && b_r[31] ? -b_r : b_r;
  // b_r is zero before and after PREP exactly when B was zero
  assign dz = is_div && b_r == '0;
  assign s = {acc[30:0], mq[31]};
  // a set rem[31] means the shifted remainder exceeds 32 bits, so it always covers the divisor
  assign take = acc[31] || s >= b_r;
  assign carry = bus.alu_result < acc;
  assign prod = neg_res ? -{acc, mq} : {acc, mq};
  assign bus.busy = st != IDLE;
  assign bus.alu_req = bus.busy;
  assign bus.done = st == DONE;
  assign bus.hi = hi_r;
  assign bus.lo = lo_r;
  always_ff @(posedge clk)
    if (reset) st <= IDLE;
    else st <= st_n;
  always_comb begin
    st_n = st;
    bus.alu_a = '0;
    bus.alu_b = '0;
    bus.alu_control = ALU_ADD;
    case (st)
      IDLE: st_n = bus.start ? PREP : IDLE;
      PREP: st_n = dz ? FIX : ITER;
      ITER: begin
        st_n = cnt == '0 ? FIX : ITER;
        bus.alu_a = is_div ? s : acc;
        bus.alu_b = is_div ? b_r : (mq[0] ? a_r : '0);
        bus.alu_control = is_div ? ALU_SUB : ALU_ADD;
      end
      FIX: st_n = DONE;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      case (st)
        IDLE: if (bus.start) begin
          op_r <= bus.op;
          a_r <= bus.A;
          b_r <= bus.B;
        end
        PREP: begin
          a_r <= a_abs;
          b_r <= b_abs;
          neg_res <= sgn && (a_r[31] ^ b_r[31]);
          neg_rem <= sgn && a_r[31];
          cnt <= 5'd31;
          acc <= '0;
          mq <= is_div ? a_abs : b_abs;
        end
        ITER: begin
          cnt <= cnt - 5'd1;
          acc <= is_div ? (take ? bus.alu_result : s) : {carry, bus.alu_result[31:1]};
          mq <= is_div ? {mq[30:0], take} : {bus.alu_result[0], mq[31:1]};
        end
        FIX: begin
          // divide by zero: re-signing the stored magnitude restores the original dividend
          if (dz) begin
            hi_r <= neg_rem ? -a_r : a_r;
            lo_r <= '1;
          end else if (is_div) begin
            hi_r <= neg_rem ? -acc : acc;
            lo_r <= neg_res ? -mq : mq;
          end else begin
            {hi_r, lo_r} <= prod;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb_mult_div_sequencer: randomized and directed checks of mult_div_sequencer against an arithmetic model
module tb_mult_div_sequencer;
  import md_pkg::*;
  logic clk = 0;
  logic reset = 1;
  int npass = 0;
  int ntot = 0;
  logic [63:0] prev_hl = '0;
  mult_div_sequencer_if bus();
  mult_div_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.alu_result = bus.alu_control == ALU_SUB ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (o[1] && b == 0) return {a, 32'hFFFFFFFF};
    case (o)
      MD_MULT: return sa * sb;
      MD_MULTU: return {32'b0, a} * {32'b0, b};
      MD_DIV: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {a % b, a / b};
    endcase
  endfunction
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input int again_at, input int rst_at);
    logic [63:0] exp, hl_done;
    int last, done_at, ndone, bad;
    exp = model(o, a, b);
    last = (o[1] && b == 0) ? 3 : 35;
    done_at = 0;
    ndone = 0;
    bad = 0;
    hl_done = '0;
    @(negedge clk);
    bus.start = 1;
    bus.op = o;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    bus.start = 0;
    bus.A = $urandom;
    bus.B = $urandom;
    for (int c = 1; c <= last + 1; c++) begin
      if (c == again_at) begin
        bus.start = 1;
        bus.op = ~o;
        bus.A = $urandom;
        bus.B = $urandom;
      end
      if (c == rst_at) reset = 1;
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (done_at == 0) done_at = c;
      end
      if (rst_at != 0 && c == rst_at + 1) begin
        check({tag, " busy"}, 64'(bus.busy), 0);
        check({tag, " hilo"}, {bus.hi, bus.lo}, 0);
        check({tag, " no done"}, 64'(ndone), 0);
        check({tag, " stable"}, 64'(bad), 0);
        prev_hl = '0;
        return;
      end
      if (bus.busy !== (c <= last) || bus.alu_req !== bus.busy) bad++;
      if (c < last && {bus.hi, bus.lo} !== prev_hl) bad++;
      if (c == last) hl_done = {bus.hi, bus.lo};
      @(posedge clk);
      #1;
      bus.start = 0;
      reset = 0;
    end
    check({tag, " done_at"}, 64'(done_at), 64'(last));
    check({tag, " ndone"}, 64'(ndone), 1);
    check({tag, " busy/hold"}, 64'(bad), 0);
    check({tag, " hilo"}, hl_done, exp);
    prev_hl = exp;
  endtask
  initial begin
    logic [1:0] o;
    logic [31:0] a, b;
    bus.start = 0;
    bus.op = 0;
    bus.A = 0;
    bus.B = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("reset busy/done/req", {61'b0, bus.busy, bus.done, bus.alu_req}, 0);
    check("reset hilo", {bus.hi, bus.lo}, 0);
    check("reset alu_ab", {bus.alu_a, bus.alu_b}, 0);
    check("reset alu_control", 64'(bus.alu_control), 64'(3'b010));
    run("multu 7*6", MD_MULTU, 32'd7, 32'd6, 0, 0);
    run("multu max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    run("mult -3*5", MD_MULT, -32'sd3, 32'd5, 0, 0);
    run("divu 100/7", MD_DIVU, 32'd100, 32'd7, 0, 0);
    run("div -7/2", MD_DIV, -32'sd7, 32'd2, 0, 0);
    run("div by zero", MD_DIV, 32'h1234, 32'd0, 0, 0);
    run("div overflow", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    run("ignored start", MD_MULTU, 32'd7, 32'd6, 5, 0);
    run("reset mid", MD_MULTU, 32'h12345, 32'h777, 0, 10);
    run("after reset", MD_MULTU, 32'd9, 32'd9, 0, 0);
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      run($sformatf("rand%0d op%0d", i, o), o, a, b, 0, 0);
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/mult_div_sequencer.md
# mult_div_sequencer

Multi-cycle multiply/divide sequencer for the MIPS EXECUTE stage. It accepts MULT/MULTU/DIV/DIVU requests and drives the shared 32-bit ALU for 32 iterations: shift-add for multiply, restoring subtract for divide. It holds the architectural HI/LO registers and presents busy/done so the hazard unit can stall dependent MFHI/MFLO. The outer EXECUTE mux gives the ALU to this block whenever `alu_req` is high.

## Interface
- No parameters; datapath width fixed at 32.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request strobe; sampled only when idle.
- `op`  in  2  2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- `A`, `B`  in  32  operands (multiplicand/multiplier, dividend/divisor); sampled with `start`.
- `alu_result`  in  32  result from shared ALU, same cycle (combinational).
- `alu_req`  out  1  sequencer owns ALU; equals `busy`.
- `alu_a`, `alu_b`  out  32  ALU operands.
- `alu_control`  out  3  ALU opcode: 3'b010 add, 3'b110 subtract.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle completion pulse.
- `hi`, `lo`  out  32  HI/LO registers.

## Operation
- Reset values: IDLE state, `hi`=`lo`=0, `busy`=`done`=`alu_req`=0, `alu_a`=`alu_b`=0, `alu_control`=3'b010.
- FSM: IDLE -> PREP -> ITER(x32) -> FIX -> DONE -> IDLE. For divide-by-zero: IDLE -> PREP -> FIX -> DONE.
- IDLE: `start`=1 latches `op`, `A`, `B` and goes to PREP. `start` in any other state is ignored; no queueing.
- PREP: for signed ops, take magnitudes of both operands and record `neg_res` = sign(A) XOR sign(B) and `neg_rem` = sign(A). Unsigned ops clear both flags. Iteration counter loads 31.
- ITER multiply: 65-bit {c, acc, mq}; init acc=0, mq=|B|. Drive `alu_a`=acc, `alu_b`= mq[0] ? |A| : 0, `alu_control`=010. Compute carry c = (`alu_result` < acc), unsigned. Next {acc, mq} = {c, `alu_result`, mq} >> 1.
- ITER divide (restoring): init rem=0, q=|A|. Form s = {rem[30:0], q[31]}. Drive `alu_a`=s, `alu_b`=|B|, `alu_control`=110.
  - If rem[31] or s >= |B| (unsigned): rem=`alu_result`, q={q[30:0],1}.
  - Otherwise: rem=s, q={q[30:0],0}.
- Counter decrements each ITER cycle; leave ITER after the cycle with counter 0.
- FIX, multiply: if `neg_res`, negate the 64-bit {acc, mq}; write `hi`=upper, `lo`=lower.
- FIX, divide: `lo`=q, negated if `neg_res`; `hi`=rem, negated if `neg_rem`.
- Divide by zero (B=0): `hi`=A, `lo`=32'hFFFFFFFF.
- Overflow case 0x80000000 / -1 (DIV): `lo`=0x80000000, `hi`=0. This falls out of the magnitude arithmetic; no special case needed.
- `hi`/`lo` change only in FIX and on reset.
- DONE: `done`=1 for one cycle, then IDLE.
- `alu_a`/`alu_b` are don't-care outside ITER but are held at 0. `alu_control` is 010 outside ITER.

## Timing
- Start accepted at edge 0 (FSM in IDLE, `start`=1).
- `busy`=1 from cycle 1 through the DONE cycle inclusive.
- Normal op: PREP cycle 1, ITER cycles 2-33, FIX cycle 34.
- Normal op: `done`=1 in cycle 35; new `hi`/`lo` visible from cycle 35.
- Divide by zero: `done` in cycle 3.
- Back-to-back: the earliest next accepted `start` is the cycle after DONE.
- `reset` has priority in every state. Mid-operation reset returns to IDLE next cycle, discards the operation, clears `hi`/`lo`, and emits no `done`.
- ALU path is combinational within one ITER cycle: `alu_a`/`alu_b`/`alu_control` come from registered state; `alu_result` is consumed at the same edge.

## Structure
- Shared package `md_pkg`:
  - op codes: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - state encoding: IDLE, PREP, ITER, FIX, DONE.
  - ALU opcode constants: ALU_ADD=3'b010, ALU_SUB=3'b110 (shared with the ALU control decoder).
- Single module, no sub-modules. The ALU is external and shared through `alu_req`.
- Negation and unsigned compare stay local to this module.

## Test plan
- MULTU A=7, B=6 -> `done` exactly at cycle 35; `hi`=0, `lo`=42; `busy` high cycles 1-35.
- MULTU A=B=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001 (carry path). MULT A=-3, B=5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- DIVU A=100, B=7 -> `lo`=14, `hi`=2. DIV A=-7, B=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV A=0x1234, B=0 -> `done` at cycle 3, `hi`=0x1234, `lo`=0xFFFFFFFF. DIV A=0x80000000, B=-1 -> `lo`=0x80000000, `hi`=0.
- `start` pulsed again at cycle 5 with different operands -> ignored; first result unchanged; `done` single pulse at 35.
- `reset` at cycle 10 of a MULTU -> cycle 11: `busy`=0, `hi`=`lo`=0, no `done`; a fresh `start` then completes normally.
